// File: rtl/vai_reset_seq.sv
// Per-sub-AFU reset sequencer: block Tx, drain outstanding c0/c1 traffic (or time out),
// hold the AFU in reset for a fixed window, then release it. One independent FSM per AFU.
module vai_reset_seq #(
  parameter int NUM_SUB_AFUS   = 9,
  parameter int CNT_W          = 10,
  parameter int QUIESCE_CYCLES = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic                    pClk,
  input  logic                    SoftReset_n,
  input  logic [NUM_SUB_AFUS-1:0] reset_req,
  input  logic [NUM_SUB_AFUS-1:0] tx_c0_issue,
  input  logic [NUM_SUB_AFUS-1:0] tx_c1_issue,
  input  logic [NUM_SUB_AFUS-1:0] rx_c0_rsp,
  input  logic [NUM_SUB_AFUS-1:0] rx_c1_rsp,
  output logic [NUM_SUB_AFUS-1:0] tx_block,
  output logic [NUM_SUB_AFUS-1:0] afu_reset,
  output logic [NUM_SUB_AFUS-1:0] seq_busy,
  output logic [NUM_SUB_AFUS-1:0] seq_done,
  output logic [NUM_SUB_AFUS-1:0] timeout_err,
  output logic [NUM_SUB_AFUS-1:0] count_err
);

  localparam int QW  = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam int TW  = (DRAIN_TIMEOUT  > 1) ? $clog2(DRAIN_TIMEOUT)  : 1;
  localparam int HW  = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
  localparam int SW  = CNT_W + 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    DRAIN   = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } seqState_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SUB_AFUS; gi++) begin : gAfu
      seqState_t               state;
      logic                    reqQ;
      logic                    pending;
      logic                    timeoutErr;
      logic                    countErr;
      logic [CNT_W-1:0]        cnt;
      logic [QW-1:0]           qCnt;
      logic [TW-1:0]           tmo;
      logic [HW-1:0]           hCnt;
      logic                    startEv;
      logic                    rspOn;
      logic signed [SW-1:0]    cntSum;
      logic                    underflow;
      logic                    overflow;
      logic [CNT_W-1:0]        cntNext;

      assign startEv = reset_req[gi] & ~reqQ;

      // Sign bit flags a negative result; the next bit alone flags exceeding 2^CNT_W-1.
      always_comb begin
        rspOn     = (state != HOLD) && (state != RELEASE);
        cntSum    = {2'b00, cnt}
                  + SW'(tx_c0_issue[gi]) + SW'(tx_c1_issue[gi])
                  - SW'(rx_c0_rsp[gi] & rspOn) - SW'(rx_c1_rsp[gi] & rspOn);
        underflow = cntSum[SW-1];
        overflow  = ~cntSum[SW-1] & cntSum[CNT_W];
        cntNext   = cntSum[CNT_W-1:0];
        if (underflow) begin
          cntNext = '0;
        end else if (overflow) begin
          cntNext = '1;
        end
      end

      always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
          state      <= IDLE;
          reqQ       <= 1'b0;
          pending    <= 1'b0;
          timeoutErr <= 1'b0;
          countErr   <= 1'b0;
          cnt        <= '0;
          qCnt       <= '0;
          tmo        <= '0;
          hCnt       <= '0;
        end else begin
          reqQ <= reset_req[gi];
          cnt  <= cntNext;
          if (underflow || overflow) begin
            countErr <= 1'b1;
          end
          if (startEv && (state != IDLE)) begin
            pending <= 1'b1;
          end
          case (state)
            IDLE: begin
              if (startEv || pending) begin
                state   <= QUIESCE;
                qCnt    <= QW'(QUIESCE_CYCLES - 1);
                pending <= 1'b0;
              end
            end
            QUIESCE: begin
              if (qCnt == '0) begin
                state <= DRAIN;
                tmo   <= TW'(DRAIN_TIMEOUT - 1);
              end else begin
                qCnt <= qCnt - QW'(1);
              end
            end
            DRAIN: begin
              // Entering HOLD discards whatever is still counted as outstanding.
              if (cnt == '0) begin
                state <= HOLD;
                hCnt  <= HW'(HOLD_CYCLES - 1);
                cnt   <= '0;
              end else if (tmo == '0) begin
                timeoutErr <= 1'b1;
                state      <= HOLD;
                hCnt       <= HW'(HOLD_CYCLES - 1);
                cnt        <= '0;
              end else begin
                tmo <= tmo - TW'(1);
              end
            end
            HOLD: begin
              if (hCnt == '0) begin
                state <= RELEASE;
              end else begin
                hCnt <= hCnt - HW'(1);
              end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      assign tx_block[gi]    = (state != IDLE);
      assign seq_busy[gi]    = (state != IDLE);
      assign afu_reset[gi]   = (state == HOLD);
      assign seq_done[gi]    = (state == RELEASE);
      assign timeout_err[gi] = timeoutErr;
      assign count_err[gi]   = countErr;
    end
  endgenerate

endmodule

// File: tb/tb_vai_reset_seq.sv
// Bench for vai_reset_seq: directed scenarios plus random traffic, every cycle compared
// against a cycle-count based reference model of each AFU's reset sequence.
module tb_vai_reset_seq;

  localparam int N    = 9;
  localparam int CW   = 4;
  localparam int QC   = 4;
  localparam int HC   = 16;
  localparam int DT   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic         pClk        = 1'b0;
  logic         SoftReset_n = 1'b0;
  logic [N-1:0] reset_req   = '0;
  logic [N-1:0] tx_c0_issue = '0;
  logic [N-1:0] tx_c1_issue = '0;
  logic [N-1:0] rx_c0_rsp   = '0;
  logic [N-1:0] rx_c1_rsp   = '0;
  logic [N-1:0] tx_block;
  logic [N-1:0] afu_reset;
  logic [N-1:0] seq_busy;
  logic [N-1:0] seq_done;
  logic [N-1:0] timeout_err;
  logic [N-1:0] count_err;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 quiesce, 2 drain, 3 hold, 4 release; el = cycles spent in phase.
  int stage [N];
  int el    [N];
  int mcnt  [N];
  bit reqQm [N];
  bit pend  [N];
  bit tErr  [N];
  bit cErr  [N];

  vai_reset_seq #(
    .NUM_SUB_AFUS  (N),
    .CNT_W         (CW),
    .QUIESCE_CYCLES(QC),
    .HOLD_CYCLES   (HC),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .reset_req   (reset_req),
    .tx_c0_issue (tx_c0_issue),
    .tx_c1_issue (tx_c1_issue),
    .rx_c0_rsp   (rx_c0_rsp),
    .rx_c1_rsp   (rx_c1_rsp),
    .tx_block    (tx_block),
    .afu_reset   (afu_reset),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .count_err   (count_err)
  );

  always #5 pClk = ~pClk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      stage[i] = 0; el[i] = 0; mcnt[i] = 0;
      reqQm[i] = 1'b0; pend[i] = 1'b0; tErr[i] = 1'b0; cErr[i] = 1'b0;
    end
  endfunction

  function automatic void modelStep();
    if (!SoftReset_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit start;
      int v;
      int oldCnt;
      int oldStage;
      start    = reset_req[i] && !reqQm[i];
      oldCnt   = mcnt[i];
      oldStage = stage[i];
      v = oldCnt + int'(tx_c0_issue[i]) + int'(tx_c1_issue[i]);
      if (oldStage != 3 && oldStage != 4) v = v - int'(rx_c0_rsp[i]) - int'(rx_c1_rsp[i]);
      if (v < 0) begin
        v = 0; cErr[i] = 1'b1;
      end else if (v > CMAX) begin
        v = CMAX; cErr[i] = 1'b1;
      end
      case (oldStage)
        0: if (start || pend[i]) begin stage[i] = 1; el[i] = 0; pend[i] = 1'b0; end
        1: begin
          el[i]++;
          if (el[i] == QC) begin stage[i] = 2; el[i] = 0; end
        end
        2: begin
          if (oldCnt == 0) begin
            stage[i] = 3; el[i] = 0; v = 0;
          end else begin
            el[i]++;
            if (el[i] == DT) begin tErr[i] = 1'b1; stage[i] = 3; el[i] = 0; v = 0; end
          end
        end
        3: begin
          el[i]++;
          if (el[i] == HC) begin stage[i] = 4; el[i] = 0; end
        end
        default: begin stage[i] = 0; el[i] = 0; end
      endcase
      if (start && oldStage != 0) pend[i] = 1'b1;
      mcnt[i]  = v;
      reqQm[i] = reset_req[i];
    end
  endfunction

  task automatic compareAll();
    logic [N-1:0] eTx, eRst, eDone, eTo, eCe;
    for (int i = 0; i < N; i++) begin
      eTx[i]   = (stage[i] != 0);
      eRst[i]  = (stage[i] == 3);
      eDone[i] = (stage[i] == 4);
      eTo[i]   = tErr[i];
      eCe[i]   = cErr[i];
    end
    checkVal("tx_block",    64'(tx_block),    64'(eTx));
    checkVal("afu_reset",   64'(afu_reset),   64'(eRst));
    checkVal("seq_busy",    64'(seq_busy),    64'(eTx));
    checkVal("seq_done",    64'(seq_done),    64'(eDone));
    checkVal("timeout_err", 64'(timeout_err), 64'(eTo));
    checkVal("count_err",   64'(count_err),   64'(eCe));
  endtask

  task automatic tick();
    @(posedge pClk);
    modelStep();
    @(negedge pClk);
    compareAll();
    tx_c0_issue = '0; tx_c1_issue = '0; rx_c0_rsp = '0; rx_c1_rsp = '0;
  endtask

  task automatic waitStage(input int i, input int st, input int limit, input string tag);
    int n;
    bit reached;
    n = 0;
    while (stage[i] != st && n < limit) begin
      tick();
      n++;
    end
    reached = (stage[i] == st);
    checkVal(tag, 64'(reached), 64'd1);
  endtask

  task automatic latencyToReset(input int i, input int exp, input string tag);
    int n;
    n = 0;
    while (!afu_reset[i] && n < 100) begin
      tick();
      n++;
    end
    checkVal(tag, 64'(n), 64'(exp));
  endtask

  initial begin
    modelReset();
    repeat (3) tick();
    checkVal("rst_outputs", 64'({tx_block, afu_reset, seq_busy, seq_done, timeout_err, count_err}), 64'd0);
    SoftReset_n = 1'b1;
    repeat (5) tick();

    // Idle counter on AFU 2; level held high must not retrigger.
    begin
      int txCnt, rstCnt, doneCnt;
      txCnt = 0; rstCnt = 0; doneCnt = 0;
      reset_req[2] = 1'b1;
      tick();
      checkVal("idle_latency", 64'(tx_block[2]), 64'd1);
      txCnt++;
      repeat (40) begin
        tick();
        txCnt   += int'(tx_block[2]);
        rstCnt  += int'(afu_reset[2]);
        doneCnt += int'(seq_done[2]);
      end
      checkVal("idle_tx_cycles",  64'(txCnt),   64'(QC + 1 + HC + 1));
      checkVal("idle_rst_cycles", 64'(rstCnt),  64'(HC));
      checkVal("idle_done_count", 64'(doneCnt), 64'd1);
      reset_req[2] = 1'b0;
      tick();
    end

    // Drain wait on AFU 0: three reads answered inside the drain window.
    repeat (3) begin tx_c0_issue[0] = 1'b1; tick(); end
    reset_req[0] = 1'b1;
    tick();
    repeat (QC + 1) tick();
    repeat (3) begin rx_c0_rsp[0] = 1'b1; tick(); end
    checkVal("drain_hold_pre", 64'(afu_reset[0]), 64'd0);
    tick();
    checkVal("drain_hold_rise", 64'(afu_reset[0]), 64'd1);
    waitStage(0, 0, 40, "drain_idle");
    checkVal("drain_no_timeout", 64'(timeout_err[0]), 64'd0);
    reset_req[0] = 1'b0;
    tick();

    // Timeout on AFU 0: one write never answered.
    tx_c1_issue[0] = 1'b1;
    tick();
    reset_req[0] = 1'b1;
    tick();
    latencyToReset(0, QC + DT, "tmo_latency");
    checkVal("tmo_err", 64'(timeout_err[0]), 64'd1);
    waitStage(0, 0, 40, "tmo_idle");
    reset_req[0] = 1'b0;
    tick();
    reset_req[0] = 1'b1;
    tick();
    latencyToReset(0, QC + 1, "post_tmo_latency");
    waitStage(0, 0, 40, "post_tmo_idle");
    reset_req[0] = 1'b0;
    tick();

    // Pending request on AFU 1: low/high toggle during HOLD.
    begin
      int n;
      reset_req[1] = 1'b1;
      tick();
      waitStage(1, 3, 30, "pend_hold");
      repeat (2) tick();
      reset_req[1] = 1'b0;
      tick();
      reset_req[1] = 1'b1;
      tick();
      n = 0;
      while (!seq_done[1] && n < 40) begin tick(); n++; end
      checkVal("pend_first_done", 64'(seq_done[1]), 64'd1);
      tick();
      checkVal("pend_idle_gap", 64'(tx_block[1]), 64'd0);
      tick();
      checkVal("pend_restart", 64'(tx_block[1]), 64'd1);
      waitStage(1, 0, 40, "pend_second_idle");
      reset_req[1] = 1'b0;
      tick();
    end

    // Counter errors: underflow on AFU 4, netting on AFU 5, saturation on AFU 6.
    rx_c0_rsp[4] = 1'b1;
    tick();
    checkVal("underflow_err", 64'(count_err[4]), 64'd1);
    tx_c0_issue[5] = 1'b1; tx_c1_issue[5] = 1'b1; rx_c0_rsp[5] = 1'b1;
    tick();
    checkVal("net_no_err", 64'(count_err[5]), 64'd0);
    repeat (9) begin tx_c0_issue[6] = 1'b1; tx_c1_issue[6] = 1'b1; tick(); end
    checkVal("sat_err", 64'(count_err[6]), 64'd1);
    repeat (7) begin rx_c0_rsp[6] = 1'b1; rx_c1_rsp[6] = 1'b1; tick(); end
    rx_c0_rsp[6] = 1'b1;
    tick();
    reset_req[4] = 1'b1; reset_req[5] = 1'b1; reset_req[6] = 1'b1;
    tick();
    latencyToReset(4, QC + 1, "underflow_cnt_zero");
    waitStage(5, 3, 30, "net_hold");
    checkVal("net_timeout", 64'(timeout_err[5]), 64'd1);
    checkVal("sat_no_timeout", 64'(timeout_err[6]), 64'd0);
    for (int i = 4; i <= 6; i++) waitStage(i, 0, 40, "err_idle");
    reset_req = '0;
    tick();

    // Random traffic and requests on all AFUs.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 4) reset_req[i] = ~reset_req[i];
        if (stage[i] < 3) begin
          tx_c0_issue[i] = ($urandom_range(0, 7) == 0);
          tx_c1_issue[i] = ($urandom_range(0, 7) == 0);
        end
        if (mcnt[i] > 0 && $urandom_range(0, 3) == 0) rx_c0_rsp[i] = 1'b1;
        if (mcnt[i] > int'(rx_c0_rsp[i]) && $urandom_range(0, 3) == 0) rx_c1_rsp[i] = 1'b1;
        if ($urandom_range(0, 499) == 0) rx_c0_rsp[i] = 1'b1;
      end
      tick();
    end
    reset_req = '0;
    for (int i = 0; i < N; i++) waitStage(i, 0, 80, "rand_idle");

    // Asynchronous abort during HOLD of AFUs 3 and 7.
    reset_req[3] = 1'b1; reset_req[7] = 1'b1;
    tick();
    waitStage(3, 3, 30, "abort_hold");
    checkVal("abort_hold7", 64'(afu_reset[7]), 64'd1);
    repeat (3) tick();
    #2;
    SoftReset_n = 1'b0;
    reset_req   = '0;
    modelReset();
    #1;
    checkVal("abort_async", 64'({tx_block, afu_reset, seq_busy, seq_done, timeout_err, count_err}), 64'd0);
    repeat (2) tick();
    SoftReset_n = 1'b1;
    begin
      int busyCnt;
      busyCnt = 0;
      repeat (30) begin
        tick();
        busyCnt += int'(tx_block[3]) + int'(tx_block[7]) + int'(seq_done[3]) + int'(seq_done[7]);
      end
      checkVal("abort_no_resume", 64'(busyCnt), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
